// File: rtl/riscv_pkg.sv
// Shared RV64 encodings: ALU operation selects, opcodes, operand-mux selects and
// the multicycle controller state enum.
package riscv_pkg;

    localparam logic [3:0] ALU_AND = 4'b0000;
    localparam logic [3:0] ALU_OR  = 4'b0001;
    localparam logic [3:0] ALU_ADD = 4'b0010;
    localparam logic [3:0] ALU_SUB = 4'b0110;

    localparam logic [6:0] OP_R  = 7'b0110011;
    localparam logic [6:0] OP_I  = 7'b0010011;
    localparam logic [6:0] OP_LD = 7'b0000011;
    localparam logic [6:0] OP_ST = 7'b0100011;
    localparam logic [6:0] OP_BR = 7'b1100011;

    localparam logic [1:0] SRCA_PC     = 2'b00;
    localparam logic [1:0] SRCA_RS1    = 2'b01;
    localparam logic [1:0] SRCA_OLD_PC = 2'b10;

    localparam logic [1:0] SRCB_RS2  = 2'b00;
    localparam logic [1:0] SRCB_FOUR = 2'b01;
    localparam logic [1:0] SRCB_IMM  = 2'b10;

    typedef enum logic [3:0] {
        FETCH, DECODE, EXEC_R, EXEC_I, MEM_ADDR, MEM_RD, MEM_WR,
        WB_ALU, WB_MEM, BRANCH, ILL
    } state_t;

    typedef struct packed {
        logic [3:0] alu_ctl;
        logic [1:0] src_a;
        logic [1:0] src_b;
        logic       pc_write;
        logic       pc_src;
        logic       ir_write;
        logic       mem_read;
        logic       mem_write;
        logic       reg_write;
        logic       mem_to_reg;
        logic       illegal;
    } ctl_t;

endpackage

// File: rtl/riscv_mc_ctrl_if.sv
// Controller <-> datapath/memory bundle. master = controller, slave = datapath.
interface riscv_mc_ctrl_if;
    logic [6:0] OPCODE;
    logic [2:0] FUNCT3;
    logic       FUNCT7_5;
    logic       Z;
    logic       MEM_READY;
    logic [3:0] ALU_CTL;
    logic [1:0] ALU_SRC_A;
    logic [1:0] ALU_SRC_B;
    logic       PC_WRITE;
    logic       PC_SRC;
    logic       IR_WRITE;
    logic       MEM_READ;
    logic       MEM_WRITE;
    logic       REG_WRITE;
    logic       MEM_TO_REG;
    logic       ILLEGAL;
    logic [3:0] DBG_STATE;

    modport master (
        input  OPCODE, FUNCT3, FUNCT7_5, Z, MEM_READY,
        output ALU_CTL, ALU_SRC_A, ALU_SRC_B, PC_WRITE, PC_SRC, IR_WRITE,
               MEM_READ, MEM_WRITE, REG_WRITE, MEM_TO_REG, ILLEGAL, DBG_STATE
    );

    modport slave (
        output OPCODE, FUNCT3, FUNCT7_5, Z, MEM_READY,
        input  ALU_CTL, ALU_SRC_A, ALU_SRC_B, PC_WRITE, PC_SRC, IR_WRITE,
               MEM_READ, MEM_WRITE, REG_WRITE, MEM_TO_REG, ILLEGAL, DBG_STATE
    );
endinterface

// File: rtl/alu_ctl_dec.sv
// Maps {R/I class, FUNCT7_5, FUNCT3} to an ALU operation select plus a legal bit.
module alu_ctl_dec
    import riscv_pkg::*;
(
    input  logic       is_r,
    input  logic       funct7_5,
    input  logic [2:0] funct3,
    output logic [3:0] alu_ctl,
    output logic       legal
);
    always_comb begin
        alu_ctl = ALU_ADD;
        legal   = 1'b1;
        if (is_r) begin
            unique case ({funct7_5, funct3})
                4'b0000: alu_ctl = ALU_ADD;
                4'b1000: alu_ctl = ALU_SUB;
                4'b0111: alu_ctl = ALU_AND;
                4'b0110: alu_ctl = ALU_OR;
                default: legal   = 1'b0;
            endcase
        end else begin
            // immediate forms have no SUB, so FUNCT7_5 carries no meaning here
            unique case (funct3)
                3'b000:  alu_ctl = ALU_ADD;
                3'b111:  alu_ctl = ALU_AND;
                3'b110:  alu_ctl = ALU_OR;
                default: legal   = 1'b0;
            endcase
        end
    end
endmodule

// File: rtl/riscv_mc_ctrl.sv
// RV64 multicycle control FSM: fetch/decode/execute/memory/writeback sequencing.
// Optional BNE support is enabled by defining RISCV_MC_CTRL_BNE_EN.
module riscv_mc_ctrl
    import riscv_pkg::*;
#(
    parameter int WORDSIZE = 64
) (
    input  logic              CLK,
    input  logic              RST,
    riscv_mc_ctrl_if.master   bus
);
    generate
        if (WORDSIZE != 32 && WORDSIZE != 64) begin : g_ws_chk
            $error("riscv_mc_ctrl: WORDSIZE must be 32 or 64");
        end
    endgenerate

    state_t     state, state_nxt;
    ctl_t       c;
    logic [3:0] dec_ctl;
    logic       dec_legal;

    alu_ctl_dec u_dec (
        .is_r     (state == EXEC_R),
        .funct7_5 (bus.FUNCT7_5),
        .funct3   (bus.FUNCT3),
        .alu_ctl  (dec_ctl),
        .legal    (dec_legal)
    );

    always_ff @(posedge CLK) begin
        if (RST) state <= FETCH;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        c         = '0;
        c.alu_ctl = ALU_ADD;
        unique case (state)
            FETCH: begin
                c.mem_read = 1'b1;
                c.src_a    = SRCA_PC;
                c.src_b    = SRCB_FOUR;
                c.ir_write = bus.MEM_READY;
                c.pc_write = bus.MEM_READY;
                if (bus.MEM_READY) state_nxt = DECODE;
            end
            DECODE: begin
                // speculative branch target lands in ALUOut
                c.src_a = SRCA_OLD_PC;
                c.src_b = SRCB_IMM;
                unique case (bus.OPCODE)
                    OP_R:         state_nxt = EXEC_R;
                    OP_I:         state_nxt = EXEC_I;
                    OP_LD, OP_ST: state_nxt = MEM_ADDR;
                    OP_BR:        state_nxt = BRANCH;
                    default:      state_nxt = ILL;
                endcase
            end
            EXEC_R, EXEC_I: begin
                c.src_a   = SRCA_RS1;
                c.src_b   = (state == EXEC_R) ? SRCB_RS2 : SRCB_IMM;
                c.alu_ctl = dec_ctl;
                state_nxt = dec_legal ? WB_ALU : ILL;
            end
            MEM_ADDR: begin
                c.src_a   = SRCA_RS1;
                c.src_b   = SRCB_IMM;
                state_nxt = (bus.OPCODE == OP_LD) ? MEM_RD : MEM_WR;
            end
            MEM_RD: begin
                c.mem_read = 1'b1;
                if (bus.MEM_READY) state_nxt = WB_MEM;
            end
            MEM_WR: begin
                c.mem_write = 1'b1;
                if (bus.MEM_READY) state_nxt = FETCH;
            end
            WB_ALU: begin
                c.reg_write = 1'b1;
                state_nxt   = FETCH;
            end
            WB_MEM: begin
                c.reg_write  = 1'b1;
                c.mem_to_reg = 1'b1;
                state_nxt    = FETCH;
            end
            BRANCH: begin
                c.src_a   = SRCA_RS1;
                c.src_b   = SRCB_RS2;
                c.alu_ctl = ALU_SUB;
                c.pc_src  = 1'b1;
                if (bus.FUNCT3 == 3'b000) begin
                    c.pc_write = bus.Z;
                    state_nxt  = FETCH;
                end
`ifdef RISCV_MC_CTRL_BNE_EN
                else if (bus.FUNCT3 == 3'b001) begin
                    c.pc_write = ~bus.Z;
                    state_nxt  = FETCH;
                end
`endif
                else begin
                    state_nxt = ILL;
                end
            end
            ILL:     c.illegal = 1'b1;
            default: state_nxt = FETCH;
        endcase
        // reset wins over everything, dropping any in-flight memory request
        if (RST) begin
            c         = '0;
            c.alu_ctl = ALU_ADD;
        end
    end

    assign bus.ALU_CTL    = c.alu_ctl;
    assign bus.ALU_SRC_A  = c.src_a;
    assign bus.ALU_SRC_B  = c.src_b;
    assign bus.PC_WRITE   = c.pc_write;
    assign bus.PC_SRC     = c.pc_src;
    assign bus.IR_WRITE   = c.ir_write;
    assign bus.MEM_READ   = c.mem_read;
    assign bus.MEM_WRITE  = c.mem_write;
    assign bus.REG_WRITE  = c.reg_write;
    assign bus.MEM_TO_REG = c.mem_to_reg;
    assign bus.ILLEGAL    = c.illegal;
    assign bus.DBG_STATE  = state;
endmodule

// File: tb/tb_riscv_mc_ctrl.sv
// Scoreboard bench for riscv_mc_ctrl: per-instruction reference sequences are queued
// as stimulus is issued and a negedge monitor compares every cycle.
module tb_riscv_mc_ctrl;
    logic CLK = 1'b0;
    logic RST = 1'b1;
    always #5 CLK = ~CLK;

    riscv_mc_ctrl_if bus ();

    riscv_mc_ctrl #(.WORDSIZE(64)) dut (
        .CLK (CLK),
        .RST (RST),
        .bus (bus)
    );

    localparam int S_FETCH = 0, S_DECODE = 1, S_EXR = 2, S_EXI = 3, S_MADDR = 4,
                   S_MRD = 5, S_MWR = 6, S_WBA = 7, S_WBM = 8, S_BR = 9, S_ILL = 10;
    localparam logic [3:0] C_AND = 4'd0, C_OR = 4'd1, C_ADD = 4'd2, C_SUB = 4'd6;

    typedef struct packed {
        logic [3:0] st;
        logic [3:0] ctl;
        logic [1:0] a;
        logic [1:0] b;
        logic pcw, pcs, irw, mrd, mwr, rw, m2r, ill;
    } out_t;

    typedef struct packed {
        logic       rst;
        logic [6:0] op;
        logic [2:0] f3;
        logic       f7;
        logic       z;
        logic       rdy;
    } in_t;

    out_t exp_q[$];
    in_t  in_q[$];
    int   passed = 0;
    int   total  = 0;
    bit   started = 0;
    logic [6:0] c_op = '0;
    logic [2:0] c_f3 = '0;
    logic       c_f7 = 1'b0;
    logic       c_z  = 1'b0;
    int         cyc  = 0;

`ifdef RISCV_MC_CTRL_BNE_EN
    localparam bit BNE_EN = 1'b1;
`else
    localparam bit BNE_EN = 1'b0;
`endif

    function automatic out_t mk(int st);
        out_t o;
        o     = '0;
        o.st  = 4'(st);
        o.ctl = C_ADD;
        return o;
    endfunction

    task automatic put(input out_t o, input bit rdy, input bit rst);
        in_t i;
        i = '{rst: rst, op: c_op, f3: c_f3, f7: c_f7, z: c_z, rdy: rdy};
        in_q.push_back(i);
        exp_q.push_back(o);
    endtask

    task automatic do_reset(input int prev);
        put(mk(prev), 1'($urandom), 1'b1);
        put(mk(S_FETCH), 1'($urandom), 1'b1);
    endtask

    task automatic go_ill();
        out_t o;
        o = mk(S_ILL);
        o.ill = 1'b1;
        repeat (3) put(o, 1'($urandom), 1'b0);
        do_reset(S_ILL);
    endtask

    task automatic drive();
        in_t i;
        while (in_q.size() > 0) begin
            @(posedge CLK);
            #1;
            i = in_q.pop_front();
            RST           = i.rst;
            bus.OPCODE    = i.op;
            bus.FUNCT3    = i.f3;
            bus.FUNCT7_5  = i.f7;
            bus.Z         = i.z;
            bus.MEM_READY = i.rdy;
            started       = 1'b1;
        end
    endtask

    // Reference: builds the whole cycle-by-cycle output sequence of one instruction.
    // abort >= 0 asserts reset after that many stalled MEM_WR cycles.
    task automatic run_instr(input logic [6:0] op, input logic [2:0] f3, input logic f7,
                             input logic z, input int wf, input int wm, input int abort);
        out_t o;
        bit   ok;
        logic [3:0] op_ctl;
        c_op = op; c_f3 = f3; c_f7 = f7; c_z = z;
        o = mk(S_FETCH); o.mrd = 1; o.b = 2'b01;
        repeat (wf) put(o, 1'b0, 1'b0);
        o.irw = 1; o.pcw = 1;
        put(o, 1'b1, 1'b0);
        o = mk(S_DECODE); o.a = 2'b10; o.b = 2'b10;
        put(o, 1'($urandom), 1'b0);
        if (op == 7'b0110011 || op == 7'b0010011) begin
            ok = 1;
            op_ctl = C_ADD;
            if (op == 7'b0110011 && f7) begin
                if (f3 == 3'b000) op_ctl = C_SUB; else ok = 0;
            end else begin
                case (f3)
                    3'b000:  op_ctl = C_ADD;
                    3'b111:  op_ctl = C_AND;
                    3'b110:  op_ctl = C_OR;
                    default: ok = 0;
                endcase
            end
            o = mk(op == 7'b0110011 ? S_EXR : S_EXI);
            o.a = 2'b01; o.b = (op == 7'b0110011) ? 2'b00 : 2'b10;
            o.ctl = ok ? op_ctl : C_ADD;
            put(o, 1'($urandom), 1'b0);
            if (ok) begin
                o = mk(S_WBA); o.rw = 1;
                put(o, 1'($urandom), 1'b0);
            end else go_ill();
        end else if (op == 7'b0000011 || op == 7'b0100011) begin
            o = mk(S_MADDR); o.a = 2'b01; o.b = 2'b10;
            put(o, 1'($urandom), 1'b0);
            if (op == 7'b0000011) begin
                o = mk(S_MRD); o.mrd = 1;
                repeat (wm) put(o, 1'b0, 1'b0);
                put(o, 1'b1, 1'b0);
                o = mk(S_WBM); o.rw = 1; o.m2r = 1;
                put(o, 1'($urandom), 1'b0);
            end else begin
                o = mk(S_MWR); o.mwr = 1;
                if (abort >= 0) begin
                    repeat (abort) put(o, 1'b0, 1'b0);
                    do_reset(S_MWR);
                end else begin
                    repeat (wm) put(o, 1'b0, 1'b0);
                    put(o, 1'b1, 1'b0);
                end
            end
        end else if (op == 7'b1100011) begin
            o = mk(S_BR); o.a = 2'b01; o.b = 2'b00; o.ctl = C_SUB; o.pcs = 1;
            ok = (f3 == 3'b000) || (BNE_EN && f3 == 3'b001);
            if (ok) o.pcw = (f3 == 3'b000) ? z : ~z;
            put(o, 1'($urandom), 1'b0);
            if (!ok) go_ill();
        end else begin
            go_ill();
        end
        drive();
    endtask

    always @(negedge CLK) begin
        out_t e, a;
        if (started && exp_q.size() > 0) begin
            e = exp_q.pop_front();
            a = '{st: bus.DBG_STATE, ctl: bus.ALU_CTL, a: bus.ALU_SRC_A, b: bus.ALU_SRC_B,
                  pcw: bus.PC_WRITE, pcs: bus.PC_SRC, irw: bus.IR_WRITE, mrd: bus.MEM_READ,
                  mwr: bus.MEM_WRITE, rw: bus.REG_WRITE, m2r: bus.MEM_TO_REG,
                  ill: bus.ILLEGAL};
            total++;
            if (a === e) passed++;
            else $display("FAIL cycle%0d outputs actual=%h expected=%h (st ctl a b pcw pcs irw mrd mwr rw m2r ill)",
                          cyc, a, e);
            cyc++;
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog timeout");
        $fatal(1, "timeout");
    end

    initial begin
        logic [6:0] ops[5];
        logic [6:0] op;
        ops[0] = 7'b0110011; ops[1] = 7'b0010011; ops[2] = 7'b0000011;
        ops[3] = 7'b0100011; ops[4] = 7'b1100011;
        bus.OPCODE = '0; bus.FUNCT3 = '0; bus.FUNCT7_5 = 0; bus.Z = 0; bus.MEM_READY = 0;
        repeat (3) @(posedge CLK);
        do_reset(S_FETCH);
        drive();
        run_instr(7'b0110011, 3'b000, 1'b0, 1'b0, 0, 0, -1);  // ADD
        run_instr(7'b0110011, 3'b000, 1'b1, 1'b0, 0, 0, -1);  // SUB
        run_instr(7'b0010011, 3'b110, 1'b0, 1'b0, 0, 0, -1);  // ORI
        run_instr(7'b0000011, 3'b011, 1'b0, 1'b0, 0, 3, -1);  // LD, 3 wait states
        run_instr(7'b1100011, 3'b000, 1'b0, 1'b1, 0, 0, -1);  // BEQ taken
        run_instr(7'b1100011, 3'b000, 1'b0, 1'b0, 1, 0, -1);  // BEQ not taken
        run_instr(7'b1100011, 3'b001, 1'b0, 1'b0, 0, 0, -1);  // BNE
        run_instr(7'b0100011, 3'b011, 1'b0, 1'b0, 0, 0, 2);   // SD aborted by reset
        run_instr(7'b0110011, 3'b111, 1'b1, 1'b0, 0, 0, -1);  // SUB-form AND -> ILL
        run_instr(7'b1111111, 3'b000, 1'b0, 1'b0, 0, 0, -1);  // bad opcode
        for (int n = 0; n < 80; n++) begin
            if ($urandom_range(0, 5) == 5) op = 7'($urandom);
            else op = ops[$urandom_range(0, 4)];
            run_instr(op, 3'($urandom), 1'($urandom), 1'($urandom),
                      int'($urandom_range(0, 2)), int'($urandom_range(0, 2)), -1);
        end
        repeat (3) @(posedge CLK);
        total++;
        if (exp_q.size() == 0) passed++;
        else $display("FAIL scoreboard_drain pending=%0d expected=0", exp_q.size());
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
